m_mem_access: RTL and testbench

//  M-stage data-memory access unit; consumes the M pipeline register outputs (DM write enable,

---
 rtl/m_mem_access_pkg.sv | 31 +++
 rtl/m_mem_access_lane.sv | 52 +++++
 rtl/m_mem_access.sv | 156 +++++++++++++++
 tb/tb_m_mem_access.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/m_mem_access_pkg.sv
// Shared definitions for the M-stage memory access unit: DMSel codes,
// access FSM states and byte-enable patterns.
package m_mem_access_pkg;

    localparam logic [2:0] SEL_W  = 3'b000;
    localparam logic [2:0] SEL_HS = 3'b001;
    localparam logic [2:0] SEL_HU = 3'b010;
    localparam logic [2:0] SEL_BS = 3'b011;
    localparam logic [2:0] SEL_BU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Reserved codes fall through to word access.
    function automatic logic is_half(input logic [2:0] sel);
        return (sel == SEL_HS) || (sel == SEL_HU);
    endfunction

    function automatic logic is_byte(input logic [2:0] sel);
        return (sel == SEL_BS) || (sel == SEL_BU);
    endfunction

endpackage

// File: rtl/m_mem_access_lane.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data alignment/extension for one access.
module m_mem_access_lane
    import m_mem_access_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (sel)
            SEL_HS: begin
                be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            end
            SEL_HU: begin
                be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'h0000, shifted[15:0]};
            end
            SEL_BS: begin
                be        = BE_BYTE0 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            end
            SEL_BU: begin
                be        = BE_BYTE0 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'h000000, shifted[7:0]};
            end
            default: begin
                be        = BE_WORD;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/m_mem_access.sv
// M-stage data-memory access unit: issues one req/ack bus transaction per
// aligned load/store, stalls the pipeline meanwhile and ends silent accesses by timeout.
//
// state | meaning
// IDLE  | evaluate M-stage instruction, accept aligned access
// BUSY  | bus_req held, waiting for bus_ack or timeout
// DONE  | result presented for one cycle, pipeline released
module m_mem_access
    import m_mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        m_valid,
    input  logic        m_dm_we,
    input  logic        m_dm_re,
    input  logic [2:0]  m_dm_sel,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_stall,
    output logic        m_addr_exc,
    output logic [31:0] m_rdata,
    output logic        m_rdata_valid,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               err_q;
    logic               we_q;
    logic [2:0]         sel_q;
    logic [31:0]        addr_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;

    logic               access;
    logic               misaligned;
    logic               accept;
    logic               tmo;
    logic               busy;
    logic [2:0]         lane_sel;
    logic [1:0]         lane_addr;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        lane_rdata;

    assign access     = m_valid & (m_dm_we | m_dm_re);
    assign misaligned = is_half(m_dm_sel) ? m_addr[0] :
                        is_byte(m_dm_sel) ? 1'b0 : (m_addr[1:0] != 2'b00);
    assign m_addr_exc = access & misaligned;
    assign accept     = access & ~misaligned;
    assign busy       = (state == ST_BUSY);
    assign tmo        = busy & ~bus_ack & (cnt == CNT_W'(TIMEOUT - 1));

    // Lane logic serves the live instruction at accept and the latched one while busy.
    assign lane_sel  = (state == ST_IDLE) ? m_dm_sel    : sel_q;
    assign lane_addr = (state == ST_IDLE) ? m_addr[1:0] : addr_q[1:0];

    m_mem_access_lane u_lane (
        .sel       (lane_sel),
        .addr_lo   (lane_addr),
        .wdata     (m_wdata),
        .rdata     (bus_rdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    always_comb begin
        state_nxt = state;
        m_stall   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    m_stall   = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                m_stall = 1'b1;
                if (bus_ack || tmo) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= SEL_W;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                    if (accept) begin
                        we_q    <= m_dm_we;
                        sel_q   <= m_dm_sel;
                        addr_q  <= m_addr;
                        be_q    <= lane_be;
                        wdata_q <= lane_wdata;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (bus_ack) begin
                        if (!we_q) rdata_q <= lane_rdata;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        if (!we_q) rdata_q <= '0;
                    end
                end
                default: begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req       = busy;
    assign bus_we        = busy & we_q;
    assign bus_addr      = busy ? {addr_q[31:2], 2'b00} : '0;
    assign bus_be        = busy ? be_q : '0;
    assign bus_wdata     = busy ? wdata_q : '0;
    assign m_rdata       = rdata_q;
    assign m_rdata_valid = (state == ST_DONE);
    assign bus_err       = (state == ST_DONE) & err_q;

endmodule

// File: tb/tb_m_mem_access.sv
// Directed bench for m_mem_access: stores, loads, misalignment, timeout and reset mid-access.
module tb_m_mem_access;

    logic        clk;
    logic        RESET;
    logic        m_valid;
    logic        m_dm_we;
    logic        m_dm_re;
    logic [2:0]  m_dm_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_stall;
    logic        m_addr_exc;
    logic [31:0] m_rdata;
    logic        m_rdata_valid;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_vec = 0;
    int n_err = 0;

    int          r_stall, r_req, r_valid;
    logic        r_err, r_we, r_done;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_be;

    m_mem_access #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .RESET         (RESET),
        .m_valid       (m_valid),
        .m_dm_we       (m_dm_we),
        .m_dm_re       (m_dm_re),
        .m_dm_sel      (m_dm_sel),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_stall       (m_stall),
        .m_addr_exc    (m_addr_exc),
        .m_rdata       (m_rdata),
        .m_rdata_valid (m_rdata_valid),
        .bus_err       (bus_err),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m_valid  = 1'b0;
        m_dm_we  = 1'b0;
        m_dm_re  = 1'b0;
        m_dm_sel = 3'b000;
        m_addr   = '0;
        m_wdata  = '0;
    endtask

    // One access; ack_at = BUSY cycle (1-based) carrying bus_ack, 0 = never ack.
    task automatic run_acc(input logic we, input logic re, input logic [2:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata);
        r_stall = 0; r_req = 0; r_valid = 0; r_err = 1'b0; r_done = 1'b0;
        r_we = 1'b0; r_rdata = '0; r_addr = '0; r_wdata = '0; r_be = '0;
        @(posedge clk); #1;
        m_valid = 1'b1; m_dm_we = we; m_dm_re = re; m_dm_sel = sel;
        m_addr = addr; m_wdata = wdata; bus_rdata = rdata;
        for (int c = 0; c < 40 && !r_done; c++) begin
            @(negedge clk);
            if (m_stall) r_stall++;
            if (bus_req) begin
                r_req++;
                if (r_req == 1) begin
                    r_we = bus_we; r_addr = bus_addr; r_be = bus_be; r_wdata = bus_wdata;
                end
                if (r_req == ack_at) bus_ack = 1'b1;
            end
            if (m_rdata_valid) begin
                r_valid++;
                r_err   = bus_err;
                r_rdata = m_rdata;
                r_done  = 1'b1;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        idle_inputs();
        if (!r_done) chk("acc_completes", 32'd0, 32'd1);
    endtask

    initial begin
        RESET = 1'b0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 RESET = 1'b1;
        @(negedge clk);
        chk("rst_req",   {31'd0, bus_req}, 32'd0);
        chk("rst_stall", {31'd0, m_stall}, 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_valid", {31'd0, m_rdata_valid}, 32'd0);
        chk("rst_addr",  bus_addr, 32'd0);

        // SW 0x10, ack on second BUSY cycle
        run_acc(1'b1, 1'b0, 3'b000, 32'h10, 32'h12345678, 2, 32'h0);
        chk("sw_be",    {28'd0, r_be}, 32'hF);
        chk("sw_wdata", r_wdata, 32'h12345678);
        chk("sw_addr",  r_addr, 32'h10);
        chk("sw_we",    {31'd0, r_we}, 32'd1);
        chk("sw_stall", r_stall, 32'd3);
        chk("sw_valid", r_valid, 32'd1);
        chk("sw_err",   {31'd0, r_err}, 32'd0);

        // LB / LBU addr 0x13
        run_acc(1'b0, 1'b1, 3'b011, 32'h13, 32'h0, 1, 32'h80FFFFFF);
        chk("lb_be",    {28'd0, r_be}, 32'h8);
        chk("lb_rdata", r_rdata, 32'hFFFFFF80);
        chk("lb_addr",  r_addr, 32'h10);
        chk("lb_we",    {31'd0, r_we}, 32'd0);
        chk("lb_stall", r_stall, 32'd2);
        run_acc(1'b0, 1'b1, 3'b100, 32'h13, 32'h0, 1, 32'h80FFFFFF);
        chk("lbu_rdata", r_rdata, 32'h00000080);

        // SH addr 0x22; m_rdata must keep last load value
        run_acc(1'b1, 1'b0, 3'b001, 32'h22, 32'h0000BEEF, 1, 32'hDEADDEAD);
        chk("sh_be",    {28'd0, r_be}, 32'hC);
        chk("sh_wdata", r_wdata, 32'hBEEFBEEF);
        chk("sh_addr",  r_addr, 32'h20);
        chk("sh_keep",  r_rdata, 32'h00000080);

        // Both we and re set behaves as store
        run_acc(1'b1, 1'b1, 3'b011, 32'h31, 32'h000000A5, 1, 32'h11111111);
        chk("wr_both_we",   {31'd0, r_we}, 32'd1);
        chk("wr_both_data", r_wdata, 32'hA5A5A5A5);
        chk("wr_both_be",   {28'd0, r_be}, 32'h2);

        // Misaligned LW 0x06
        @(posedge clk); #1;
        m_valid = 1'b1; m_dm_re = 1'b1; m_dm_sel = 3'b000; m_addr = 32'h06;
        @(negedge clk);
        chk("mis_exc",   {31'd0, m_addr_exc}, 32'd1);
        chk("mis_stall", {31'd0, m_stall}, 32'd0);
        @(negedge clk);
        chk("mis_req",   {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();

        // Silent bus: timeout
        run_acc(1'b0, 1'b1, 3'b000, 32'h30, 32'h0, 0, 32'h55555555);
        chk("to_req",   r_req, 32'd16);
        chk("to_err",   {31'd0, r_err}, 32'd1);
        chk("to_rdata", r_rdata, 32'd0);
        chk("to_stall", r_stall, 32'd17);

        // Ack on the last BUSY cycle wins over timeout
        run_acc(1'b0, 1'b1, 3'b001, 32'h12, 32'h0, 16, 32'h80010000);
        chk("late_req",   r_req, 32'd16);
        chk("late_err",   {31'd0, r_err}, 32'd0);
        chk("late_rdata", r_rdata, 32'hFFFF8001);
        chk("late_be",    {28'd0, r_be}, 32'hC);

        // Reset during BUSY
        @(posedge clk); #1;
        m_valid = 1'b1; m_dm_re = 1'b1; m_dm_sel = 3'b000; m_addr = 32'h40;
        @(negedge clk);
        @(negedge clk);
        chk("rb_req_before", {31'd0, bus_req}, 32'd1);
        RESET = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        RESET = 1'b1;
        r_valid = 0;
        r_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (m_rdata_valid) r_valid++;
            if (bus_req) r_req++;
        end
        chk("rb_req",   r_req, 32'd0);
        chk("rb_valid", r_valid, 32'd0);
        chk("rb_rdata", m_rdata, 32'd0);
        run_acc(1'b0, 1'b1, 3'b000, 32'h40, 32'h0, 1, 32'hCAFEF00D);
        chk("rb_lw_rdata", r_rdata, 32'hCAFEF00D);
        chk("rb_lw_be",    {28'd0, r_be}, 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
